// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU scheduler: FSM state encoding, ALU op codes and bus widths.
package alu_sched_pkg;

    localparam int WORD_W = 16;
    localparam int OPND_W = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD_A,
        S_GAP,
        S_WAIT,
        S_CAP,
        S_RESP,
        S_ABORT
    } state_t;

    // Picks requester id's half out of a {word1, word0} bus.
    function automatic logic [WORD_W-1:0] sel_word(input logic [2*WORD_W-1:0] bus, input logic id);
        return id ? bus[2*WORD_W-1:WORD_W] : bus[WORD_W-1:0];
    endfunction

endpackage

// File: rtl/alu_sched_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, pointer moves to the
// requester that was not just served when update is pulsed.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       last_id,
    output logic [1:0] grant
);

    logic ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (update) begin
            ptr <= ~last_id;
        end
    end

    // A lone or absent request passes straight through; only a tie consults the pointer.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_sched.sv
// Shares one multi-cycle ALU between two requesters: arbitrates, runs clear/start/gap/operand-M
// load sequence, captures the result and returns it tagged with the id. Watchdog: ALU_SCHED_TIMEOUT_EN.
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter int GAP_CYCLES = 1,
    parameter int TIMEOUT    = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [3:0]          req_sel,
    input  logic [2*WORD_W-1:0] req_opa,
    input  logic [2*OPND_W-1:0] req_opb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [WORD_W-1:0]   rsp_data,
    output logic                rsp_err,
    output logic                busy,
    output logic                alu_rst,
    output logic                alu_start,
    output logic [1:0]          alu_sel,
    output logic [WORD_W-1:0]   alu_inbus,
    input  logic [WORD_W-1:0]   alu_outbus,
    input  logic                alu_finish
);

    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    if (GAP_CYCLES < 1 || GAP_CYCLES > 256) begin : g_bad_gap
        $error("GAP_CYCLES must be in 1..256");
    end
    if (TIMEOUT < 1 || TIMEOUT > 256) begin : g_bad_timeout
        $error("TIMEOUT must be in 1..256");
    end

    state_t              state;
    logic [1:0]          sel_q;
    logic [WORD_W-1:0]   opa_q;
    logic [OPND_W-1:0]   opb_q;
    logic                id_q;
    logic [7:0]          gap_cnt;
    logic [WORD_W-1:0]   data_q;
    logic [1:0]          grant;
    logic                win;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ((state == S_IDLE) ? req_valid : 2'b00),
        .update  ((state == S_RESP) && rsp_ready),
        .last_id (id_q),
        .grant   (grant)
    );

    assign win       = grant[1];
    assign req_ready = grant;

`ifdef ALU_SCHED_TIMEOUT_EN
    logic [7:0] wd_cnt;
    logic       err_q;
    logic       wd_expire;

    assign wd_expire = (wd_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            wd_cnt <= (state == S_WAIT) ? wd_cnt + 8'd1 : 8'd0;
            if (state == S_CAP) begin
                err_q <= 1'b0;
            end else if (state == S_ABORT) begin
                err_q <= 1'b1;
            end
        end
    end

    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            sel_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            id_q    <= 1'b0;
            gap_cnt <= '0;
            data_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|grant) begin
                        sel_q <= win ? req_sel[3:2] : req_sel[1:0];
                        opa_q <= sel_word(req_opa, win);
                        opb_q <= win ? req_opb[2*OPND_W-1:OPND_W] : req_opb[OPND_W-1:0];
                        id_q  <= win;
                        state <= S_CLEAR;
                    end
                end
                S_CLEAR:  state <= S_LOAD_A;
                S_LOAD_A: begin
                    gap_cnt <= '0;
                    state   <= S_GAP;
                end
                // finish is deliberately not looked at here; the ALU has not seen operand M yet.
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= S_WAIT;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                S_WAIT: begin
                    if (alu_finish) begin
                        state <= S_CAP;
                    end
`ifdef ALU_SCHED_TIMEOUT_EN
                    else if (wd_expire) begin
                        state <= S_ABORT;
                    end
`endif
                end
                S_CAP: begin
                    data_q <= alu_outbus;
                    state  <= S_RESP;
                end
`ifdef ALU_SCHED_TIMEOUT_EN
                S_ABORT: begin
                    data_q <= '0;
                    state  <= S_RESP;
                end
`endif
                S_RESP: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid = (state == S_RESP);
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;
    assign busy      = (state != S_IDLE);
    assign alu_rst   = rst || (state == S_CLEAR) || (state == S_ABORT);
    assign alu_start = (state == S_LOAD_A);
    assign alu_sel   = sel_q;

    always_comb begin
        alu_inbus = '0;
        case (state)
            S_LOAD_A, S_GAP: alu_inbus = opa_q;
            S_WAIT:          alu_inbus = {{(WORD_W-OPND_W){1'b0}}, opb_q};
            default:         alu_inbus = '0;
        endcase
    end

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched with a small behavioural ALU (finish 4 cycles after start).
module tb_alu_sched;

`ifdef ALU_SCHED_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 64;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [3:0]  req_sel = '0;
    logic [31:0] req_opa = '0;
    logic [15:0] req_opb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_id;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic        alu_rst;
    logic        alu_start;
    logic [1:0]  alu_sel;
    logic [15:0] alu_inbus;
    logic [15:0] alu_outbus;
    logic        alu_finish;

    int errors = 0;
    int checks = 0;

    alu_sched #(.GAP_CYCLES(1), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_sel    (req_sel),
        .req_opa    (req_opa),
        .req_opb    (req_opb),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .alu_rst    (alu_rst),
        .alu_start  (alu_start),
        .alu_sel    (alu_sel),
        .alu_inbus  (alu_inbus),
        .alu_outbus (alu_outbus),
        .alu_finish (alu_finish)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: latches A/sel on start, returns result from operand M 4 cycles later.
    logic [15:0] m_a = '0;
    logic [1:0]  m_s = '0;
    logic        m_run = 1'b0;
    int          m_cnt = 0;
    logic        m_fin = 1'b0;
    logic [15:0] m_out = '0;
    logic        never_fin = 1'b0;
    logic        spur = 1'b0;

    assign alu_finish = m_fin | spur;
    assign alu_outbus = m_out;

    function automatic logic [15:0] alu_calc(input logic [1:0] s, input logic [15:0] a, input logic [7:0] m);
        logic [15:0] aw, mw;
        aw = {8'd0, a[7:0]};
        mw = {8'd0, m};
        case (s)
            2'b00:   return aw + mw;
            2'b01:   return aw - mw;
            2'b10:   return aw * mw;
            default: return (m == 8'd0) ? 16'hFFFF : {8'(a % mw), 8'(a / mw)};
        endcase
    endfunction

    always @(posedge clk) begin
        if (alu_rst) begin
            m_run <= 1'b0;
            m_fin <= 1'b0;
            m_cnt <= 0;
        end else if (alu_start) begin
            m_a   <= alu_inbus;
            m_s   <= alu_sel;
            m_run <= 1'b1;
            m_cnt <= 0;
            m_fin <= 1'b0;
        end else if (m_run && !never_fin && m_cnt == 3) begin
            m_fin <= 1'b1;
            m_out <= alu_calc(m_s, m_a, alu_inbus[7:0]);
            m_run <= 1'b0;
        end else begin
            m_fin <= 1'b0;
            if (m_run) m_cnt <= m_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    // Waits (bounded) for rsp_valid; n = cycles waited, f = cycle finish was first seen.
    task automatic wait_rsp(output int n, output int f);
        n = -1;
        f = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (alu_finish && f < 0) f = i;
            if (rsp_valid) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        checks++;
        if ({alu_rst, busy, rsp_valid, req_ready} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_during: got %b required 10000", {alu_rst, busy, rsp_valid, req_ready});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({alu_rst, busy, rsp_valid, rsp_id, rsp_err, alu_start, alu_sel, alu_inbus, rsp_data} !== 39'd0) begin
            errors++;
            $display("FAIL reset_after: got %h required 0",
                     {alu_rst, busy, rsp_valid, rsp_id, rsp_err, alu_start, alu_sel, alu_inbus, rsp_data});
        end
    endtask

    task automatic test_add();
        int n, f;
        @(negedge clk);
        req_valid = 2'b01; req_sel = 4'b0000; req_opa = {16'd0, 16'd40}; req_opb = {8'd0, 8'd12};
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL add_grant: got %b required 01", req_ready); end
        @(negedge clk); req_valid = 2'b00; #1;
        checks++;
        if ({alu_rst, busy, alu_start} !== 3'b110) begin errors++; $display("FAIL add_clear: got %b required 110", {alu_rst, busy, alu_start}); end
        @(negedge clk); #1;
        checks++;
        if ({alu_start, alu_sel, alu_inbus} !== {1'b1, 2'b00, 16'd40}) begin
            errors++; $display("FAIL add_load_a: got %h required %h", {alu_start, alu_sel, alu_inbus}, {1'b1, 2'b00, 16'd40});
        end
        @(negedge clk); #1;
        checks++;
        if ({alu_start, alu_inbus} !== {1'b0, 16'd40}) begin
            errors++; $display("FAIL add_gap: got %h required %h", {alu_start, alu_inbus}, {1'b0, 16'd40});
        end
        @(negedge clk); #1;
        checks++;
        if (alu_inbus !== 16'd12) begin errors++; $display("FAIL add_opb: got %0d required 12", alu_inbus); end
        wait_rsp(n, f);
        checks++;
        if (n < 0 || f < 0 || n - f != 2) begin errors++; $display("FAIL add_latency: got n=%0d f=%0d required n-f=2", n, f); end
        checks++;
        if ({rsp_id, rsp_err, rsp_data} !== {1'b0, 1'b0, 16'd52}) begin
            errors++; $display("FAIL add_result: got id=%0d err=%0d data=%0d required 0 0 52", rsp_id, rsp_err, rsp_data);
        end
        ack(); #1;
        checks++;
        if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL add_release: got %b required 00", {rsp_valid, busy}); end
    endtask

    task automatic test_arb();
        int n, f;
        // Fresh reset so requester 0 holds priority.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        req_valid = 2'b11; req_sel = {2'b10, 2'b01}; req_opa = {16'd40, 16'd40}; req_opb = {8'd12, 8'd12};
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL arb_first_grant: got %b required 01", req_ready); end
        @(negedge clk); req_valid = 2'b10;
        wait_rsp(n, f);
        checks++;
        if (n < 0 || {rsp_id, rsp_data} !== {1'b0, 16'd28}) begin
            errors++; $display("FAIL arb_first_rsp: got n=%0d id=%0d data=%0d required id=0 data=28", n, rsp_id, rsp_data);
        end
        checks++;
        if (req_ready !== 2'b00) begin errors++; $display("FAIL resp_no_early_accept: got %b required 00", req_ready); end
        ack(); #1;
        checks++;
        if (req_ready !== 2'b10) begin errors++; $display("FAIL arb_second_grant: got %b required 10", req_ready); end
        @(negedge clk); req_valid = 2'b00;
        wait_rsp(n, f);
        checks++;
        if (n < 0 || {rsp_id, rsp_data} !== {1'b1, 16'h01E0}) begin
            errors++; $display("FAIL arb_second_rsp: got n=%0d id=%0d data=%h required id=1 data=01e0", n, rsp_id, rsp_data);
        end
        ack(); #1;
    endtask

    task automatic test_alternate();
        logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [1:0] g;
        int n, f;
        @(negedge clk);
        req_valid = 2'b11; req_sel = 4'b0000; req_opa = {16'd40, 16'd40}; req_opb = {8'd12, 8'd12};
        #1;
        for (int i = 0; i < 4; i++) begin
            g = req_ready;
            checks++;
            if (g !== exp_g[i]) begin errors++; $display("FAIL alt_grant[%0d]: got %b required %b", i, g, exp_g[i]); end
            @(negedge clk); req_valid = 2'b10;
            wait_rsp(n, f);
            checks++;
            if (n < 0 || {rsp_id, rsp_data} !== {exp_g[i][1], 16'd52}) begin
                errors++; $display("FAIL alt_rsp[%0d]: got id=%0d data=%0d required id=%0d data=52", i, rsp_id, rsp_data, exp_g[i][1]);
            end
            req_valid = (i < 3) ? 2'b11 : 2'b00;
            ack(); #1;
        end
    endtask

    task automatic test_stall();
        int n, f;
        int bad = 0;
        @(negedge clk);
        req_valid = 2'b01; req_sel = {2'b10, 2'b00}; req_opa = {16'd40, 16'd40}; req_opb = {8'd12, 8'd12};
        @(negedge clk); req_valid = 2'b00;
        wait_rsp(n, f);
        req_valid = 2'b10;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if ({rsp_valid, rsp_data, req_ready, busy} !== {1'b1, 16'd52, 2'b00, 1'b1}) bad++;
        end
        checks++;
        if (n < 0 || bad != 0) begin errors++; $display("FAIL stall_hold: got n=%0d bad_cycles=%0d required 0", n, bad); end
        ack(); #1;
        checks++;
        if (req_ready !== 2'b10) begin errors++; $display("FAIL stall_next_grant: got %b required 10", req_ready); end
        @(negedge clk); req_valid = 2'b00;
        wait_rsp(n, f);
        checks++;
        if (n < 0 || {rsp_id, rsp_data} !== {1'b1, 16'h01E0}) begin
            errors++; $display("FAIL stall_next_rsp: got id=%0d data=%h required id=1 data=01e0", rsp_id, rsp_data);
        end
        ack(); #1;
    endtask

    task automatic test_gap_finish();
        int n, f;
        @(negedge clk);
        req_valid = 2'b01; req_sel = 4'b0001; req_opa = {16'd0, 16'd40}; req_opb = {8'd0, 8'd12};
        @(negedge clk); req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk); spur = 1'b1;
        @(negedge clk); spur = 1'b0; #1;
        checks++;
        if ({alu_inbus, rsp_valid, busy} !== {16'd12, 1'b0, 1'b1}) begin
            errors++; $display("FAIL gap_finish_ignored: got inbus=%0d valid=%0d busy=%0d required 12 0 1", alu_inbus, rsp_valid, busy);
        end
        wait_rsp(n, f);
        checks++;
        if (n < 0 || rsp_data !== 16'd28) begin errors++; $display("FAIL gap_finish_rsp: got n=%0d data=%0d required 28", n, rsp_data); end
        ack(); #1;
    endtask

    task automatic test_rst_mid();
        int n, f;
        bit seen = 1'b0;
        @(negedge clk);
        req_valid = 2'b01; req_sel = 4'b0010; req_opa = {16'd40, 16'd40}; req_opb = {8'd12, 8'd12};
        @(negedge clk); req_valid = 2'b00;
        repeat (4) @(negedge clk);
        rst = 1'b1; #1;
        checks++;
        if ({busy, rsp_valid, req_ready, alu_start, alu_rst, alu_sel, alu_inbus, rsp_data, rsp_id, rsp_err} !== {5'b00001, 36'd0}) begin
            errors++; $display("FAIL rst_mid_outputs: got %h required %h",
                {busy, rsp_valid, req_ready, alu_start, alu_rst, alu_sel, alu_inbus, rsp_data, rsp_id, rsp_err}, {5'b00001, 36'd0});
        end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            if (rsp_valid || busy) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL rst_no_resp: got activity=1 required 0"); end
        @(negedge clk);
        req_valid = 2'b10; req_sel = {2'b10, 2'b00}; #1;
        checks++;
        if (req_ready !== 2'b10) begin errors++; $display("FAIL lone_grant: got %b required 10", req_ready); end
        @(negedge clk); req_valid = 2'b00; #1;
        checks++;
        if (alu_rst !== 1'b1) begin errors++; $display("FAIL restart_clear: got %b required 1", alu_rst); end
        @(negedge clk); #1;
        checks++;
        if ({alu_start, alu_sel, alu_inbus} !== {1'b1, 2'b10, 16'd40}) begin
            errors++; $display("FAIL restart_load: got %h required %h", {alu_start, alu_sel, alu_inbus}, {1'b1, 2'b10, 16'd40});
        end
        wait_rsp(n, f);
        checks++;
        if (n < 0 || {rsp_id, rsp_data} !== {1'b1, 16'h01E0}) begin
            errors++; $display("FAIL restart_rsp: got n=%0d id=%0d data=%h required id=1 data=01e0", n, rsp_id, rsp_data);
        end
        ack(); #1;
    endtask

`ifdef ALU_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int n = -1;
        bit rst_seen = 1'b0;
        never_fin = 1'b1;
        @(negedge clk);
        req_valid = 2'b01; req_sel = 4'b0000; req_opa = {16'd0, 16'd40}; req_opb = {8'd0, 8'd12};
        @(negedge clk); req_valid = 2'b00;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (alu_inbus !== 16'd12) begin errors++; $display("FAIL timeout_opb: got %0d required 12", alu_inbus); end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (alu_rst) rst_seen = 1'b1;
            if (rsp_valid) begin n = i; break; end
        end
        // 16 WAIT cycles from the first opb cycle, then the abort cycle, then RESP.
        checks++;
        if (n != TO) begin errors++; $display("FAIL timeout_latency: got %0d required %0d", n, TO); end
        checks++;
        if ({rsp_err, rsp_data, rst_seen} !== {1'b1, 16'd0, 1'b1}) begin
            errors++; $display("FAIL timeout_rsp: got err=%0d data=%0d alu_rst_pulse=%0d required 1 0 1", rsp_err, rsp_data, rst_seen);
        end
        never_fin = 1'b0;
        ack(); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_arb();
        test_alternate();
        test_stall();
        test_gap_finish();
        test_rst_mid();
`ifdef ALU_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_sched.md
# alu_sched

Two-requester scheduler that shares the single 8-bit multi-cycle ALU (add/sub/mul/div) between two clients. It arbitrates round-robin and accepts one operation at a time. It sequences the ALU's load protocol (clear, start with operand A, gap, operand M), waits for `finish`, captures `outbus`, and returns the result tagged with the requester id. It sits between the client request buses and the ALU instance.

## Interface
Parameters:
- `GAP_CYCLES`, default 1: cycles `inbus` holds operand A with `start` low, before operand M is driven (≥1).
- `TIMEOUT`, default 64: maximum cycles spent in WAIT before abort. Used only with the macro.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset. Asynchronous, active-high.
- `req_valid`  in  2: per-requester request valid.
- `req_ready`  out  2: per-requester accept. One-hot or zero.
- `req_sel`  in  4: `{sel1, sel0}` op code. 00 add, 01 sub, 10 mul, 11 div.
- `req_opa`  in  32: `{opa1, opa0}`. First operand word, 16 b each; div uses `[15:8]:[7:0]` as A:Q.
- `req_opb`  in  16: `{opb1, opb0}`. Operand M, 8 b each.
- `rsp_valid`  out  1: result valid.
- `rsp_ready`  in  1: result accepted.
- `rsp_id`  out  1: requester index of the result.
- `rsp_data`  out  16: captured ALU result.
- `rsp_err`  out  1: operation aborted by timeout.
- `busy`  out  1: high whenever state ≠ IDLE.
- `alu_rst`  out  1: ALU reset.
- `alu_start`  out  1: ALU start.
- `alu_sel`  out  2: ALU op select.
- `alu_inbus`  out  16: ALU input bus.
- `alu_outbus`  in  16: ALU result bus.
- `alu_finish`  in  1: ALU done.

## Operation
- FSM states: IDLE → CLEAR → LOAD_A → GAP → WAIT → CAP → RESP → IDLE.
- All ALU-side outputs and `rsp_*` are decoded from registered state and registers only (Moore). `req_ready` is the one combinational output.

State behaviour:
- **IDLE:** if any `req_valid` is set, the arbiter picks a winner and `req_ready[w]=1` in that cycle. On handshake, latch sel, opa, opb and id, then go to CLEAR.
- **CLEAR:** `alu_rst=1` for 1 cycle.
- **LOAD_A:** `alu_start=1`, `alu_sel`=sel, `alu_inbus`=opa, for 1 cycle.
- **GAP:** `alu_start=0`, `alu_inbus`=opa, for `GAP_CYCLES`, counted by the gap counter.
- **WAIT:** `alu_inbus={8'b0, opb}`; `alu_sel` is held for the whole operation. Go to CAP when `alu_finish=1`.
- **CAP:** register `alu_outbus` into `rsp_data`, clear `rsp_err`, go to RESP.
- **RESP:** `rsp_valid=1`, held with stable data until `rsp_ready`. Then go to IDLE and point priority at the other requester.

Arbitration rules:
- Round-robin between the two requesters. After reset requester 0 has priority.
- A lone requester is granted regardless of the pointer.
- Requesters hold valid and payload stable until ready. Dropping valid before ready is permitted and yields no grant.

Boundary conditions:
- `rsp_ready` and a new `req_valid` in the same RESP cycle: the request is accepted no earlier than the next IDLE cycle.
- `alu_finish` seen in the GAP cycle is ignored; only WAIT samples it.
- `rst` mid-operation: the FSM goes to IDLE and the in-flight op is dropped with no response.

## Timing
- Reset values: `req_ready=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_data=0`, `rsp_err=0`, `busy=0`, `alu_start=0`, `alu_sel=0`, `alu_inbus=0`. `alu_rst` is 1 while `rst` is high, 0 after.
- Accept at cycle 0 → `alu_rst` in cycle 1 → `alu_start` in cycle 2 → opb first driven in cycle 3+`GAP_CYCLES`.
- `alu_finish` first seen in WAIT cycle F → CAP in F+1 → `rsp_valid` from F+2.
- Minimum IDLE-to-IDLE time = 5 + `GAP_CYCLES` + WAIT length + response stall.

## Configuration
- With `ALU_SCHED_TIMEOUT_EN` defined:
  - An 8-bit watchdog counts WAIT cycles.
  - When the count reaches `TIMEOUT` without `finish`: go to RESP with `rsp_err=1` and `rsp_data=0`, and pulse `alu_rst` for 1 cycle on the way.
- Without the macro:
  - WAIT is unbounded.
  - `rsp_err` is tied 0.
  - No watchdog logic is present.

## Structure
- `alu_sched_pkg`: state enum, op codes `OP_ADD/OP_SUB/OP_MUL/OP_DIV`, `WORD_W=16`, `OPND_W=8`.
- Sub-module `rr_arb2`: 2-way round-robin arbiter with pointer register, `update` input, one-hot grant output.
- The FSM, gap counter, watchdog and payload registers live in the top.

## Test plan
- Req0 add, opa=40, opb=12, ALU model with finish after 4 cycles → `alu_start` 1 cycle, `inbus` 40 then 12; `rsp_id=0`, `rsp_data=52`, `rsp_err=0`.
- Req0 sub (40, 12) and req1 mul (40, 12) valid together → req0 served first with 28, then req1 with 480 (0x01E0), `rsp_id` 0 then 1.
- Req1 held valid continuously plus repeated req0 → grants alternate 0,1,0,1; no starvation.
- `rsp_ready` held low for 10 cycles → `rsp_valid`/`rsp_data` stable, `req_ready` stays 0 and `busy=1`.
- `rst` asserted during WAIT → all outputs return to reset values the same cycle; next request restarts cleanly from CLEAR.
- Macro on, `TIMEOUT=16`, finish never asserted → `rsp_err=1`, `rsp_data=0` delivered 16 WAIT cycles after opb first driven, with an `alu_rst` pulse beforehand.
